// File: rtl/mat_mult_ctrl.sv
// Sequencing controller for an external NxN matrix multiplier: streams A and B in
// row-major order, holds them on a_bus/b_bus, captures c_bus after a settle delay, streams C out.
module mat_mult_ctrl #(
    parameter int BITS   = 8,
    parameter int N      = 4,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS-1:0]       in_data,
    output logic [N*N*BITS-1:0]   a_bus,
    output logic [N*N*BITS-1:0]   b_bus,
    input  logic [N*N*BITS-1:0]   c_bus,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITS-1:0]       out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    // state     | meaning
    // ST_IDLE   | waiting for start
    // ST_LOAD_A | accepting A elements, row-major
    // ST_LOAD_B | accepting B elements, row-major
    // ST_SETTLE | operands held stable while the datapath settles; c_bus captured on last cycle
    // ST_OUT    | streaming result elements, row-major

    localparam int NE = N * N;
    localparam int IW = $clog2(NE);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IW-1:0] IDX_LAST    = IW'(NE - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_SETTLE,
        ST_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic                done_q, done_d;
    logic [NE*BITS-1:0]  a_q, b_q, res_q;
    logic                a_we, b_we, res_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        done_d   = 1'b0;
        a_we     = 1'b0;
        b_we     = 1'b0;
        res_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_A;
                    idx_d   = '0;
                end
            end
            ST_LOAD_A: begin
                if (in_valid) begin
                    a_we = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_LOAD_B;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_LOAD_B: begin
                if (in_valid) begin
                    b_we = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d  = ST_SETTLE;
                        settle_d = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    res_we  = 1'b1;
                    state_d = ST_OUT;
                    idx_d   = '0;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        // Abort wins over any transfer in the same cycle; operand/result storage is left untouched.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b0;
            a_we    = 1'b0;
            b_we    = 1'b0;
            res_we  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            if (a_we)   a_q[BITS*int'(idx_q) +: BITS] <= in_data;
            if (b_we)   b_q[BITS*int'(idx_q) +: BITS] <= in_data;
            if (res_we) res_q <= c_bus;
        end
    end

    // Handshake/status outputs decode only state and index, never in_valid/out_ready.
    assign in_ready  = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    assign out_valid = (state_q == ST_OUT);
    assign out_last  = (state_q == ST_OUT) && (idx_q == IDX_LAST);
    assign out_data  = (state_q == ST_OUT) ? res_q[BITS*int'(idx_q) +: BITS] : '0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign a_bus     = a_q;
    assign b_bus     = b_q;

endmodule

// File: tb/tb_mat_mult_ctrl.sv
// Directed bench for mat_mult_ctrl (N=2, BITS=8, SETTLE=2) with a behavioural 2x2 multiplier
// standing in for the datapath; expected results are hand-computed constants.
module tb_mat_mult_ctrl;

    localparam int BITS   = 8;
    localparam int N      = 2;
    localparam int SETTLE = 2;
    localparam int W      = N*N*BITS;

    logic           clk = 1'b0;
    logic           rst;
    logic           start, abort, in_valid, out_ready;
    logic           in_ready, out_valid, out_last, busy, done;
    logic [BITS-1:0] in_data, out_data;
    logic [W-1:0]   a_bus, b_bus, c_bus;

    int n_tests = 0;
    int n_fail  = 0;

    mat_mult_ctrl #(.BITS(BITS), .N(N), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .a_bus(a_bus), .b_bus(b_bus), .c_bus(c_bus),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [7:0] acc;
        c_bus = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                acc = 8'd0;
                for (int k = 0; k < 2; k++)
                    acc = acc + 8'(a_bus[8*(i*2+k) +: 8] * b_bus[8*(k*2+j) +: 8]);
                c_bus[8*(i*2+j) +: 8] = acc;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mats(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input bit in_stall, input bit start_in_b);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".busy_after_start"}, busy, 1);
        chk({tag, ".in_ready_load"}, in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            if (in_stall) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = (i < 4) ? a[8*i +: 8] : b[8*(i-4) +: 8];
            start    = start_in_b && (i == 5);
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk({tag, ".in_ready_settle"}, in_ready, 0);
    endtask

    task automatic wait_out(input string tag, input logic [31:0] a, input logic [31:0] b);
        int waited = 0;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        chk({tag, ".settle_cycles"}, waited, SETTLE);
        chk({tag, ".a_bus"}, a_bus, a);
        chk({tag, ".b_bus"}, b_bus, b);
    endtask

    task automatic drain(input string tag, input logic [31:0] exp, input bit out_stall);
        for (int i = 0; i < 4; i++) begin
            if (out_stall && i == 1) begin
                out_ready = 1'b0;
                repeat (3) begin
                    chk({tag, ".stall_hold"}, out_data, exp[8*i +: 8]);
                    tick();
                end
            end
            chk({tag, $sformatf(".data%0d", i)}, out_data, exp[8*i +: 8]);
            chk({tag, $sformatf(".last%0d", i)}, out_last, (i == 3));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk({tag, ".done_pulse"}, done, 1);
        chk({tag, ".busy_idle"}, busy, 0);
        chk({tag, ".out_valid_idle"}, out_valid, 0);
        tick();
        chk({tag, ".done_clear"}, done, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".in_ready"}, in_ready, 0);
        chk({tag, ".out_valid"}, out_valid, 0);
        chk({tag, ".out_last"}, out_last, 0);
        chk({tag, ".out_data"}, out_data, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".a_bus"}, a_bus, 0);
        chk({tag, ".b_bus"}, b_bus, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_done;
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #1;
        check_all_zero("reset");
        tick(); tick();
        rst = 1'b0;
        tick();
        check_all_zero("post_reset");

        // identity A, no stalls
        load_mats("ident", pk(1,0,0,1), pk(5,6,7,8), 0, 0);
        wait_out("ident", pk(1,0,0,1), pk(5,6,7,8));
        drain("ident", pk(5,6,7,8), 0);

        // general product with input and output stalls
        load_mats("stall", pk(1,2,3,4), pk(5,6,7,8), 1, 0);
        wait_out("stall", pk(1,2,3,4), pk(5,6,7,8));
        drain("stall", pk(19,22,43,50), 1);

        // modulo wrap
        load_mats("wrap256", pk(16,0,0,16), pk(16,0,0,16), 0, 0);
        wait_out("wrap256", pk(16,0,0,16), pk(16,0,0,16));
        drain("wrap256", pk(0,0,0,0), 0);
        load_mats("wrap510", pk(255,0,0,0), pk(2,0,0,0), 0, 0);
        wait_out("wrap510", pk(255,0,0,0), pk(2,0,0,0));
        drain("wrap510", pk(254,0,0,0), 0);

        // abort after 3rd A element, with a 4th element offered in the abort cycle
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'd9; tick();
        end
        in_data = 8'd7; abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0; in_valid = 1'b0;
        chk("abort.busy", busy, 0);
        chk("abort.in_ready", in_ready, 0);
        chk("abort.a_bus", a_bus, pk(9,9,9,0));
        seen_done = 1'b0;
        repeat (3) begin
            seen_done |= done;
            tick();
        end
        chk("abort.no_done", seen_done, 0);
        chk("abort.still_idle", busy, 0);

        // fresh job after abort, start pulsed during LOAD_B must be ignored
        load_mats("after_abort", pk(2,0,0,2), pk(1,2,3,4), 0, 1);
        wait_out("after_abort", pk(2,0,0,2), pk(1,2,3,4));
        drain("after_abort", pk(2,4,6,8), 0);

        // reset during OUT after two transfers
        load_mats("rst_mid", pk(1,2,3,4), pk(5,6,7,8), 0, 0);
        wait_out("rst_mid", pk(1,2,3,4), pk(5,6,7,8));
        for (int i = 0; i < 2; i++) begin
            out_ready = 1'b1; tick();
        end
        chk("rst_mid.data2", out_data, 43);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (4) begin
            seen_done |= done | busy;
            tick();
        end
        chk("rst_mid.no_restart", seen_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
